pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the pipelined core's fetch stage, replacing the plain PC register. It holds the fetch PC and sequences it through boot, run and halt. It offers the PC to instruction memory over a valid/ready handshake. It arbitrates the next PC among trap entry, trap return, branch/jump redirect and sequential increment, and it keeps the exception PC (EPC).

## Interface
Parameters:
- XLEN, 32, PC/address width in bits
- RESET_VECTOR, 0, PC loaded by reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry
- ILEN_BYTES, 4, sequential increment; power of two; alignment granule

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous reset, active-high
- stall  in  1  hazard-unit hold; blocks sequential advance
- redirect_valid  in  1  branch/jump resolved in EX
- redirect_target  in  XLEN  redirect destination
- trap_req  in  1  take trap this cycle
- trap_epc  in  XLEN  PC of the trapping instruction
- mret  in  1  return from trap to EPC
- halt_req  in  1  request fetch halt
- resume  in  1  leave HALT
- fetch_ready  in  1  IMEM accepts pc_out
- fetch_valid  out  1  pc_out is a valid fetch request
- pc_out  out  XLEN  current fetch PC
- pc_plus  out  XLEN  pc_out + ILEN_BYTES (combinational, for link/JAL)
- epc_out  out  XLEN  saved exception PC
- misaligned  out  1  one-cycle pulse: redirect target was misaligned
- state_out  out  2  current FSM state

## Operation
- States: BOOT=0, RUN=1, HALT=2. The encoding 3 is never used; if reached, the FSM goes to BOOT.
- Reset, sampled on a clk edge with rst=1:
  - state=BOOT, pc_out=RESET_VECTOR, epc_out=0, misaligned=0.
  - rst overrides every other input, including mid-handshake.
- BOOT:
  - fetch_valid=0.
  - Goes to RUN unconditionally next cycle; the PC is unchanged.
- RUN: fetch_valid=1. The next PC is chosen by priority, highest first:
  1. trap_req: pc←TRAP_VECTOR, epc←trap_epc, state stays RUN.
  2. mret: pc←epc_out.
  3. redirect_valid with aligned target: pc←redirect_target.
  4. redirect_valid with misaligned target (target mod ILEN_BYTES ≠ 0): pc←TRAP_VECTOR, epc←redirect_target, misaligned=1 for one cycle.
  5. halt_req: state←HALT, pc holds.
  6. fetch_ready & ~stall: pc←pc_out+ILEN_BYTES.
  7. Otherwise: pc holds.
- Priorities 1–4 ignore stall and fetch_ready; a redirect flushes.
- HALT:
  - fetch_valid=0.
  - trap_req performs a trap entry and goes to RUN.
  - resume goes to RUN with the PC unchanged.
  - mret and redirect are ignored.
  - halt_req held high has no further effect.
- Arithmetic:
  - All PC adds are modulo 2^XLEN, so all-ones minus 3 plus 4 wraps to 0.
  - TRAP_VECTOR and RESET_VECTOR are trusted to be aligned.
- Handshake:
  - While fetch_valid=1 and fetch_ready=0, pc_out stays stable unless a priority 1–4 event occurs.
  - IMEM discards a request abandoned this way.

## Timing
- All state updates happen on the clk rising edge; there are no combinational paths from inputs to pc_out, epc_out or fetch_valid.
- pc_plus is combinational from pc_out.
- Redirect latency: the target appears on pc_out one cycle after redirect_valid is sampled.
- After rst deasserts:
  - cycle 0 is BOOT (fetch_valid=0);
  - cycle 1 is RUN with pc_out=RESET_VECTOR and fetch_valid=1.
- Back-to-back redirects in consecutive cycles each take effect; the last one wins.
- If trap_req and mret are both high, the trap wins and epc gets trap_epc; mret is lost.

## Structure
- Shared package pc_pkg holds:
  - the state enum (PC_BOOT, PC_RUN, PC_HALT);
  - the width localparam for state_out;
  - the default vector constants.
- One sub-module is natural: pc_next_sel, the combinational priority mux producing the next PC, next EPC and the misaligned flag.
- The FSM and registers stay in pc_unit.

## Test plan
- Reset/boot: rst high 2 cycles then low -> cycle 0: state=BOOT, fetch_valid=0; cycle 1: pc_out=0, fetch_valid=1; with fetch_ready=1, pc_out steps 0,4,8,C.
- Stall and backpressure:
  - stall=1 at pc=8 for 3 cycles -> pc_out stays 8, then advances to C.
  - fetch_ready=0 -> pc_out also holds.
- Redirect priority:
  - redirect_target=0x40 together with stall=1 -> pc_out=0x40 next cycle.
  - Same cycle with trap_req=1 and trap_epc=0x1C -> pc_out=0x100, epc_out=0x1C; then mret -> pc_out=0x1C.
- Misaligned target: redirect_target=0x42 -> pc_out=0x100, epc_out=0x42, misaligned high exactly 1 cycle.
- Halt/resume:
  - halt_req at pc=0x20 -> state=HALT, fetch_valid=0, pc holds 0x20; redirect in HALT is ignored.
  - resume -> RUN at 0x20.
  - A separate halt episode with trap_req in HALT -> RUN at 0x100.
- Wrap and mid-operation reset:
  - XLEN=32, redirect to 0xFFFF_FFFC then advance -> pc_out=0.
  - rst asserted during a stalled fetch -> next cycle state=BOOT, pc_out=RESET_VECTOR, epc_out=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage program-counter unit.
package pc_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    PC_BOOT = 2'd0,
    PC_RUN  = 2'd1,
    PC_HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
  localparam int          DEFAULT_ILEN_BYTES   = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Priority mux for the next fetch PC, next EPC and the misaligned-redirect flag.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int             XLEN        = 32,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int             ILEN_BYTES  = DEFAULT_ILEN_BYTES
) (
  input  pc_state_e         state,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   epc,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  input  logic              trap_req,
  input  logic [XLEN-1:0]   trap_epc,
  input  logic              mret,
  input  logic              halt_req,
  input  logic              fetch_ready,
  output logic [XLEN-1:0]   pc_inc,
  output logic [XLEN-1:0]   pc_next,
  output logic [XLEN-1:0]   epc_next,
  output logic              misaligned_next
);

  localparam logic [XLEN-1:0] ILEN_W     = XLEN'(ILEN_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ILEN_W - XLEN'(1);

  logic target_misaligned;

  assign pc_inc            = pc + ILEN_W;
  assign target_misaligned = (redirect_target & ALIGN_MASK) != {XLEN{1'b0}};

  // Next-PC arbitration; a misaligned redirect is converted into a trap entry
  always_comb begin
    pc_next         = pc;
    epc_next        = epc;
    misaligned_next = 1'b0;
    case (state)
      PC_RUN: begin
        if (trap_req) begin
          pc_next  = TRAP_VECTOR;
          epc_next = trap_epc;
        end else if (mret) begin
          pc_next = epc;
        end else if (redirect_valid) begin
          if (target_misaligned) begin
            pc_next         = TRAP_VECTOR;
            epc_next        = redirect_target;
            misaligned_next = 1'b1;
          end else begin
            pc_next = redirect_target;
          end
        end else if (halt_req) begin
          pc_next = pc;
        end else if (fetch_ready && !stall) begin
          pc_next = pc_inc;
        end else begin
          pc_next = pc;
        end
      end
      PC_HALT: begin
        if (trap_req) begin
          pc_next  = TRAP_VECTOR;
          epc_next = trap_epc;
        end else begin
          pc_next = pc;
        end
      end
      default: begin
        pc_next = pc;
      end
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: BOOT/RUN/HALT sequencing, IMEM valid/ready request,
// trap entry/return and EPC storage.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int              ILEN_BYTES   = DEFAULT_ILEN_BYTES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_target,
  input  logic               trap_req,
  input  logic [XLEN-1:0]    trap_epc,
  input  logic               mret,
  input  logic               halt_req,
  input  logic               resume,
  input  logic               fetch_ready,
  output logic               fetch_valid,
  output logic [XLEN-1:0]    pc_out,
  output logic [XLEN-1:0]    pc_plus,
  output logic [XLEN-1:0]    epc_out,
  output logic               misaligned,
  output logic [STATE_W-1:0] state_out
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            misaligned_q, misaligned_d;
  logic            fetch_valid_q;

  pc_next_sel #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR),
    .ILEN_BYTES  (ILEN_BYTES)
  ) u_next_sel (
    .state           (state_q),
    .pc              (pc_q),
    .epc             (epc_q),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_req        (trap_req),
    .trap_epc        (trap_epc),
    .mret            (mret),
    .halt_req        (halt_req),
    .fetch_ready     (fetch_ready),
    .pc_inc          (pc_plus),
    .pc_next         (pc_d),
    .epc_next        (epc_d),
    .misaligned_next (misaligned_d)
  );

  // State transitions; halt only wins in RUN when no trap, mret or redirect is pending
  always_comb begin
    state_d = state_q;
    case (state_q)
      PC_BOOT: state_d = PC_RUN;
      PC_RUN: begin
        if (!trap_req && !mret && !redirect_valid && halt_req) begin
          state_d = PC_HALT;
        end else begin
          state_d = PC_RUN;
        end
      end
      PC_HALT: begin
        if (trap_req || resume) begin
          state_d = PC_RUN;
        end else begin
          state_d = PC_HALT;
        end
      end
      default: state_d = PC_BOOT;
    endcase
  end

  // All architectural state; fetch_valid is registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= PC_BOOT;
      pc_q          <= RESET_VECTOR;
      epc_q         <= {XLEN{1'b0}};
      misaligned_q  <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      misaligned_q  <= misaligned_d;
      fetch_valid_q <= (state_d == PC_RUN);
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign pc_out      = pc_q;
  assign epc_out     = epc_q;
  assign misaligned  = misaligned_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with hand-computed expected values.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_req;
  logic [31:0] trap_epc;
  logic        mret;
  logic        halt_req;
  logic        resume;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus;
  logic [31:0] epc_out;
  logic        misaligned;
  logic [1:0]  state_out;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] S_BOOT = 32'd0;
  localparam logic [31:0] S_RUN  = 32'd1;
  localparam logic [31:0] S_HALT = 32'd2;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_req        (trap_req),
    .trap_epc        (trap_epc),
    .mret            (mret),
    .halt_req        (halt_req),
    .resume          (resume),
    .fetch_ready     (fetch_ready),
    .fetch_valid     (fetch_valid),
    .pc_out          (pc_out),
    .pc_plus         (pc_plus),
    .epc_out         (epc_out),
    .misaligned      (misaligned),
    .state_out       (state_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    trap_req = 1'b0; trap_epc = 32'h0; mret = 1'b0; halt_req = 1'b0;
    resume = 1'b0; fetch_ready = 1'b1;
    tick(); tick();
    check_eq("rst_state", {30'd0, state_out}, S_BOOT);
    check_eq("rst_pc", pc_out, 32'h0);
    check_eq("rst_epc", epc_out, 32'h0);
    check_eq("rst_mis", {31'd0, misaligned}, 32'd0);
    check_eq("rst_fv", {31'd0, fetch_valid}, 32'd0);

    rst = 1'b0;
    check_eq("boot_state", {30'd0, state_out}, S_BOOT);
    tick();
    check_eq("run_state", {30'd0, state_out}, S_RUN);
    check_eq("run_fv", {31'd0, fetch_valid}, 32'd1);
    check_eq("run_pc0", pc_out, 32'h0);
    tick(); check_eq("seq_pc4", pc_out, 32'h4);
    tick(); check_eq("seq_pc8", pc_out, 32'h8);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check_eq("stall_hold", pc_out, 32'h8);
    end
    stall = 1'b0;
    tick(); check_eq("stall_release", pc_out, 32'hC);
    check_eq("pc_plus", pc_plus, 32'h10);

    fetch_ready = 1'b0;
    tick(); check_eq("bp_hold1", pc_out, 32'hC);
    tick(); check_eq("bp_hold2", pc_out, 32'hC);
    check_eq("bp_fv", {31'd0, fetch_valid}, 32'd1);
    fetch_ready = 1'b1;

    // redirect ignores stall; back-to-back redirects each land
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
    tick(); check_eq("redir_stall", pc_out, 32'h40);
    redirect_target = 32'h50;
    tick(); check_eq("redir_b2b", pc_out, 32'h50);
    stall = 1'b0;

    // trap beats redirect and mret in the same cycle
    redirect_target = 32'h60; trap_req = 1'b1; trap_epc = 32'h1C; mret = 1'b1;
    tick();
    check_eq("trap_pc", pc_out, 32'h100);
    check_eq("trap_epc", epc_out, 32'h1C);
    redirect_valid = 1'b0; trap_req = 1'b0;
    tick(); check_eq("mret_pc", pc_out, 32'h1C);
    mret = 1'b0;
    tick(); check_eq("post_mret", pc_out, 32'h20);

    redirect_valid = 1'b1; redirect_target = 32'h42;
    tick();
    check_eq("mis_pc", pc_out, 32'h100);
    check_eq("mis_epc", epc_out, 32'h42);
    check_eq("mis_pulse", {31'd0, misaligned}, 32'd1);
    check_eq("mis_state", {30'd0, state_out}, S_RUN);
    redirect_valid = 1'b0;
    tick();
    check_eq("mis_clear", {31'd0, misaligned}, 32'd0);
    check_eq("mis_next", pc_out, 32'h104);

    redirect_valid = 1'b1; redirect_target = 32'h20;
    tick(); check_eq("redir_20", pc_out, 32'h20);
    redirect_valid = 1'b0; halt_req = 1'b1;
    tick();
    check_eq("halt_state", {30'd0, state_out}, S_HALT);
    check_eq("halt_fv", {31'd0, fetch_valid}, 32'd0);
    check_eq("halt_pc", pc_out, 32'h20);
    redirect_valid = 1'b1; redirect_target = 32'h80; mret = 1'b1;
    tick();
    check_eq("halt_ign_state", {30'd0, state_out}, S_HALT);
    check_eq("halt_ign_pc", pc_out, 32'h20);
    check_eq("halt_ign_epc", epc_out, 32'h42);
    redirect_valid = 1'b0; mret = 1'b0; halt_req = 1'b0; resume = 1'b1;
    tick();
    check_eq("resume_state", {30'd0, state_out}, S_RUN);
    check_eq("resume_pc", pc_out, 32'h20);
    check_eq("resume_fv", {31'd0, fetch_valid}, 32'd1);
    resume = 1'b0;
    tick(); check_eq("resume_adv", pc_out, 32'h24);

    halt_req = 1'b1;
    tick();
    check_eq("halt2_state", {30'd0, state_out}, S_HALT);
    check_eq("halt2_pc", pc_out, 32'h24);
    halt_req = 1'b0; trap_req = 1'b1; trap_epc = 32'h24;
    tick();
    check_eq("halt_trap_state", {30'd0, state_out}, S_RUN);
    check_eq("halt_trap_pc", pc_out, 32'h100);
    check_eq("halt_trap_epc", epc_out, 32'h24);
    trap_req = 1'b0;

    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    check_eq("wrap_pc", pc_out, 32'hFFFF_FFFC);
    check_eq("wrap_plus", pc_plus, 32'h0);
    redirect_valid = 1'b0;
    tick(); check_eq("wrap_adv", pc_out, 32'h0);
    tick(); check_eq("wrap_adv4", pc_out, 32'h4);

    fetch_ready = 1'b0; stall = 1'b1;
    tick(); check_eq("pre_rst_hold", pc_out, 32'h4);
    rst = 1'b1;
    tick();
    check_eq("mid_rst_state", {30'd0, state_out}, S_BOOT);
    check_eq("mid_rst_pc", pc_out, 32'h0);
    check_eq("mid_rst_epc", epc_out, 32'h0);
    check_eq("mid_rst_fv", {31'd0, fetch_valid}, 32'd0);
    rst = 1'b0; stall = 1'b0; fetch_ready = 1'b1;
    tick();
    check_eq("mid_rst_run", {30'd0, state_out}, S_RUN);
    check_eq("mid_rst_pc0", pc_out, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
